// File: rtl/spi_pkg.sv
// Shared types and default frame widths for the SPI command master.
package spi_pkg;

   localparam int CMD_TX_W = 56;
   localparam int CMD_RX_W = 48;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SCK_HI,
      ST_SCK_LO,
      ST_HOLD,
      ST_GAP
   } spi_mst_state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Loadable down-counter. It raises tick for one cycle in the last cycle of a loaded interval,
// so a load of N followed by a tick spans exactly N clk cycles.
module spi_tick_gen #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tick
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign tick = (cnt == W'(1));

endmodule

// File: rtl/spi_cmd_master.sv
// SPI mode-0 command initiator: shifts out one TX_WIDTH-bit command MSB first and
// returns the first RX_WIDTH bits sampled on miso as the response word.
module spi_cmd_master
   import spi_pkg::*;
#(
   parameter int TX_WIDTH = CMD_TX_W,
   parameter int RX_WIDTH = CMD_RX_W,
   parameter int CLK_DIV  = 4,
   parameter int SS_GUARD = 8
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                start,
   input  logic [TX_WIDTH-1:0] tx_data,
   output logic                ready,
   output logic                busy,
   output logic [RX_WIDTH-1:0] rx_data,
   output logic                rx_valid,
   output logic                spi_clk,
   output logic                spi_ss,
   output logic                spi_mosi,
   input  logic                spi_miso
);

   localparam int DIV_MAX = (CLK_DIV > SS_GUARD) ? CLK_DIV : SS_GUARD;
   localparam int DW      = $clog2(DIV_MAX + 1);
   localparam int BW      = $clog2(TX_WIDTH + 1);

   if (CLK_DIV < 4) begin : g_chk_div
      $error("spi_cmd_master: CLK_DIV must be >= 4");
   end
   if (SS_GUARD < 2) begin : g_chk_guard
      $error("spi_cmd_master: SS_GUARD must be >= 2");
   end
   if (RX_WIDTH > TX_WIDTH) begin : g_chk_rx
      $error("spi_cmd_master: RX_WIDTH must be <= TX_WIDTH");
   end

   spi_mst_state_t      state, state_nx;
   logic                tick;
   logic                ld;
   logic [DW-1:0]       ld_val;
   logic                do_accept, do_rise, do_fall, do_done;
   logic [BW-1:0]       bit_cnt;
   logic [TX_WIDTH-2:0] tx_sr;
   logic [RX_WIDTH-1:0] rx_sr;
   logic [1:0]          miso_sync;

   spi_tick_gen #(.W(DW)) u_tick (
      .clk      (clk),
      .nrst     (nrst),
      .load     (ld),
      .load_val (ld_val),
      .tick     (tick)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      ld        = 1'b0;
      ld_val    = '0;
      do_accept = 1'b0;
      do_rise   = 1'b0;
      do_fall   = 1'b0;
      do_done   = 1'b0;
      unique case (state)
         ST_IDLE: if (start) begin
            do_accept = 1'b1;
            ld        = 1'b1;
            ld_val    = DW'(SS_GUARD);
            state_nx  = ST_SETUP;
         end
         ST_SETUP: if (tick) begin
            do_rise  = 1'b1;
            ld       = 1'b1;
            ld_val   = DW'(CLK_DIV);
            state_nx = ST_SCK_HI;
         end
         ST_SCK_HI: if (tick) begin
            do_fall  = 1'b1;
            ld       = 1'b1;
            ld_val   = DW'(CLK_DIV);
            state_nx = ST_SCK_LO;
         end
         // bit_cnt already counts the falling edge that opened this low phase
         ST_SCK_LO: if (tick) begin
            ld = 1'b1;
            if (bit_cnt < BW'(TX_WIDTH)) begin
               do_rise  = 1'b1;
               ld_val   = DW'(CLK_DIV);
               state_nx = ST_SCK_HI;
            end else begin
               ld_val   = DW'(SS_GUARD);
               state_nx = ST_HOLD;
            end
         end
         ST_HOLD: if (tick) begin
            do_done  = 1'b1;
            ld       = 1'b1;
            ld_val   = DW'(SS_GUARD);
            state_nx = ST_GAP;
         end
         ST_GAP: if (tick) begin
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign ready = (state == ST_IDLE);
   assign busy  = !ready;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         spi_ss    <= 1'b1;
         spi_clk   <= 1'b0;
         spi_mosi  <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         bit_cnt   <= '0;
         miso_sync <= '0;
      end else begin
         miso_sync <= {miso_sync[0], spi_miso};
         rx_valid  <= do_done;
         if (do_accept) begin
            spi_ss   <= 1'b0;
            spi_mosi <= tx_data[TX_WIDTH-1];
            bit_cnt  <= '0;
         end
         if (do_rise) spi_clk <= 1'b1;
         if (do_fall) begin
            spi_clk  <= 1'b0;
            spi_mosi <= tx_sr[TX_WIDTH-2];
            bit_cnt  <= bit_cnt + BW'(1);
         end
         if (do_done) begin
            spi_ss   <= 1'b1;
            spi_mosi <= 1'b0;
            rx_data  <= rx_sr;
         end
      end
   end

   // The MSB leaves on mosi at accept, so only the remaining bits wait in tx_sr.
   always_ff @(posedge clk) begin
      if (do_accept)    tx_sr <= tx_data[TX_WIDTH-2:0];
      else if (do_fall) tx_sr <= tx_sr << 1;
   end

   always_ff @(posedge clk) begin
      if (do_fall && (bit_cnt < BW'(RX_WIDTH))) rx_sr <= {rx_sr[RX_WIDTH-2:0], miso_sync[1]};
   end

endmodule
